// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller:
// FSM states, opcodes, ALU encodings and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM_RD = 3'd3,
        S_MEM_WR = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_LDM = 4'b0100;
    localparam logic [3:0] OP_STM = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JZ  = 4'b0111;
    localparam logic [3:0] OP_JC  = 4'b1000;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic PC_SEL_INC  = 1'b0;
    localparam logic PC_SEL_IR   = 1'b1;
    localparam logic ACC_SEL_ALU = 1'b0;
    localparam logic ACC_SEL_MEM = 1'b1;
    localparam logic ADDR_SEL_PC = 1'b0;
    localparam logic ADDR_SEL_IR = 1'b1;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle accumulator-CPU control FSM (fetch/decode/exec/mem/halt).
// Optional retire counter output instr_cnt under MULTICYCLE_CTRL_PERF_CNT_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       carry,
    input  logic       mem_rdy,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       pc_ld,
    output logic       ir_ld,
    output logic       acc_ld,
    output logic       c_ld,
    output logic       pc_sel,
    output logic       acc_sel,
    output logic [1:0] alu_op,
    output logic       retire,
    output logic       halted
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    ,
    output logic [15:0] instr_cnt
`endif
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are gated by rst so reset silences every strobe at once
    always_comb begin
        w_next   = r_state;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = ADDR_SEL_PC;
        pc_ld    = 1'b0;
        ir_ld    = 1'b0;
        acc_ld   = 1'b0;
        c_ld     = 1'b0;
        pc_sel   = PC_SEL_INC;
        acc_sel  = ACC_SEL_ALU;
        alu_op   = ALU_ADD;
        retire   = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_FETCH: begin
                    mem_rd   = 1'b1;
                    addr_sel = ADDR_SEL_PC;
                    if (mem_rdy) begin
                        ir_ld  = 1'b1;
                        pc_ld  = 1'b1;
                        pc_sel = PC_SEL_INC;
                        w_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    w_next = S_FETCH;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                            w_next = S_EXEC;
                        end
                        OP_LDM: w_next = S_MEM_RD;
                        OP_STM: w_next = S_MEM_WR;
                        OP_JMP: begin
                            pc_ld  = 1'b1;
                            pc_sel = PC_SEL_IR;
                            retire = 1'b1;
                        end
                        OP_JZ: begin
                            pc_ld  = zero;
                            pc_sel = zero ? PC_SEL_IR : PC_SEL_INC;
                            retire = 1'b1;
                        end
                        OP_JC: begin
                            pc_ld  = carry;
                            pc_sel = carry ? PC_SEL_IR : PC_SEL_INC;
                            retire = 1'b1;
                        end
                        OP_HLT: begin
                            w_next = S_HALT;
                            retire = 1'b1;
                        end
                        default: retire = 1'b1;
                    endcase
                end
                S_EXEC: begin
                    acc_ld  = 1'b1;
                    acc_sel = ACC_SEL_ALU;
                    alu_op  = op[1:0];
                    c_ld    = (op[1:0] == ALU_ADD) || (op[1:0] == ALU_SUB);
                    retire  = 1'b1;
                    w_next  = S_FETCH;
                end
                S_MEM_RD: begin
                    mem_rd   = 1'b1;
                    addr_sel = ADDR_SEL_IR;
                    if (mem_rdy) begin
                        acc_ld  = 1'b1;
                        acc_sel = ACC_SEL_MEM;
                        retire  = 1'b1;
                        w_next  = S_FETCH;
                    end
                end
                S_MEM_WR: begin
                    mem_wr   = 1'b1;
                    addr_sel = ADDR_SEL_IR;
                    if (mem_rdy) begin
                        retire = 1'b1;
                        w_next = S_FETCH;
                    end
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [15:0] r_instr_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_cnt <= 16'd0;
        end else if (retire) begin
            r_instr_cnt <= r_instr_cnt + 16'd1;
        end
    end

    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected
// cycle sequences built from the opcode rules, random ops and waits.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic       addr_sel;
        logic       pc_ld;
        logic       ir_ld;
        logic       acc_ld;
        logic       c_ld;
        logic       pc_sel;
        logic       acc_sel;
        logic [1:0] alu_op;
        logic       retire;
        logic       halted;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] op = 4'd0;
    logic       zero = 1'b0;
    logic       carry = 1'b0;
    logic       mem_rdy = 1'b0;
    logic       mem_rd, mem_wr, addr_sel, pc_ld, ir_ld;
    logic       acc_ld, c_ld, pc_sel, acc_sel, retire, halted;
    logic [1:0] alu_op;
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [15:0] instr_cnt;
`endif

    obs_t act;
    obs_t g_exp[$];
    bit   g_rdy[$];
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    always_comb act = {mem_rd, mem_wr, addr_sel, pc_ld, ir_ld, acc_ld,
                       c_ld, pc_sel, acc_sel, alu_op, retire, halted};

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .carry(carry),
        .mem_rdy(mem_rdy), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .addr_sel(addr_sel), .pc_ld(pc_ld), .ir_ld(ir_ld),
        .acc_ld(acc_ld), .c_ld(c_ld), .pc_sel(pc_sel),
        .acc_sel(acc_sel), .alu_op(alu_op), .retire(retire),
        .halted(halted)
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
        , .instr_cnt(instr_cnt)
`endif
    );

    // Expected per-cycle outputs for one instruction, fetch through retire
    task automatic build(input logic [3:0] o, input logic z, input logic c,
                         input int wf, input int wm);
        obs_t e;
        bit   taken;
        g_exp.delete();
        g_rdy.delete();
        for (int i = 0; i < wf; i++) begin
            e = '0; e.mem_rd = 1'b1;
            g_exp.push_back(e); g_rdy.push_back(1'b0);
        end
        e = '0; e.mem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_ld = 1'b1;
        g_exp.push_back(e); g_rdy.push_back(1'b1);
        if (o <= 4'd3) begin
            e = '0;
            g_exp.push_back(e); g_rdy.push_back(1'($urandom_range(0, 1)));
            e = '0; e.acc_ld = 1'b1; e.alu_op = o[1:0];
            e.c_ld = (o <= 4'd1); e.retire = 1'b1;
            g_exp.push_back(e); g_rdy.push_back(1'($urandom_range(0, 1)));
        end else if (o == 4'd4 || o == 4'd5) begin
            e = '0;
            g_exp.push_back(e); g_rdy.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < wm; i++) begin
                e = '0; e.addr_sel = 1'b1;
                e.mem_rd = (o == 4'd4); e.mem_wr = (o == 4'd5);
                g_exp.push_back(e); g_rdy.push_back(1'b0);
            end
            e = '0; e.addr_sel = 1'b1; e.retire = 1'b1;
            e.mem_rd = (o == 4'd4); e.mem_wr = (o == 4'd5);
            e.acc_ld = (o == 4'd4); e.acc_sel = (o == 4'd4);
            g_exp.push_back(e); g_rdy.push_back(1'b1);
        end else begin
            taken = (o == 4'd6) || (o == 4'd7 && z) || (o == 4'd8 && c);
            e = '0; e.pc_ld = taken; e.pc_sel = taken; e.retire = 1'b1;
            g_exp.push_back(e); g_rdy.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset();
        obs_t e;
        @(negedge clk);
        mem_rdy = 1'b1;
        #1;
        n_chk++;
        if (act !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_outs got %h exp %h", act, obs_t'(0));
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (act !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_held got %h exp %h", act, obs_t'(0));
        end
        rst = 1'b0;
        mem_rdy = 1'b0;
        #1;
        e = '0; e.mem_rd = 1'b1;
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL first_fetch got %h exp %h", act, e);
        end
    endtask

    task automatic test_add();
        op = 4'd0; zero = 1'b0; carry = 1'b0;
        build(4'd0, 1'b0, 1'b0, 0, 0);
        foreach (g_exp[i]) begin
            mem_rdy = g_rdy[i];
            #1;
            n_chk++;
            if (act !== g_exp[i]) begin
                n_err++;
                $display("FAIL add cyc%0d got %h exp %h", i, act, g_exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ldm_wait();
        op = 4'd4; zero = 1'b1; carry = 1'b1;
        build(4'd4, 1'b1, 1'b1, 1, 4);
        foreach (g_exp[i]) begin
            mem_rdy = g_rdy[i];
            #1;
            n_chk++;
            if (act !== g_exp[i]) begin
                n_err++;
                $display("FAIL ldm_wait cyc%0d got %h exp %h", i, act, g_exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cond_jumps();
        logic [3:0] ops [4];
        logic       fl [4];
        ops = '{4'd7, 4'd8, 4'd7, 4'd8};
        fl  = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            op = ops[k];
            zero = fl[k];
            carry = fl[k];
            build(ops[k], fl[k], fl[k], 0, 0);
            foreach (g_exp[i]) begin
                mem_rdy = g_rdy[i];
                #1;
                n_chk++;
                if (act !== g_exp[i]) begin
                    n_err++;
                    $display("FAIL cond_jump op%h f%0d cyc%0d got %h exp %h",
                             ops[k], fl[k], i, act, g_exp[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [3:0] o;
        logic       z, c;
        for (int k = 0; k < 60; k++) begin
            o = 4'($urandom_range(0, 15));
            if (o == 4'd15) o = 4'd9;
            z = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            op = o; zero = z; carry = c;
            build(o, z, c, $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (g_exp[i]) begin
                mem_rdy = g_rdy[i];
                #1;
                n_chk++;
                if (act !== g_exp[i]) begin
                    n_err++;
                    $display("FAIL rand k%0d op%h cyc%0d got %h exp %h",
                             k, o, i, act, g_exp[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_stm();
        obs_t e;
        op = 4'd5; zero = 1'b0; carry = 1'b0;
        mem_rdy = 1'b1;
        #1;
        e = '0; e.mem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_ld = 1'b1;
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL stm_fetch got %h exp %h", act, e);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (act !== obs_t'(0)) begin
            n_err++;
            $display("FAIL stm_decode got %h exp %h", act, obs_t'(0));
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        #1;
        e = '0; e.mem_wr = 1'b1; e.addr_sel = 1'b1;
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL stm_wait got %h exp %h", act, e);
        end
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (act !== obs_t'(0)) begin
            n_err++;
            $display("FAIL stm_async_rst got %h exp %h", act, obs_t'(0));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        e = '0; e.mem_rd = 1'b1;
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL stm_refetch got %h exp %h", act, e);
        end
    endtask

    task automatic test_halt();
        obs_t e;
        op = 4'd15;
        build(4'd15, 1'b0, 1'b0, 1, 0);
        foreach (g_exp[i]) begin
            mem_rdy = g_rdy[i];
            #1;
            n_chk++;
            if (act !== g_exp[i]) begin
                n_err++;
                $display("FAIL hlt cyc%0d got %h exp %h", i, act, g_exp[i]);
            end
            @(negedge clk);
        end
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            mem_rdy = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            zero = 1'($urandom_range(0, 1));
            carry = 1'($urandom_range(0, 1));
            #1;
            n_chk++;
            if (act !== e) begin
                n_err++;
                $display("FAIL halted cyc%0d got %h exp %h", k, act, e);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_rdy = 1'b0;
        #1;
        e = '0; e.mem_rd = 1'b1;
        n_chk++;
        if (act !== e) begin
            n_err++;
            $display("FAIL halt_exit got %h exp %h", act, e);
        end
    endtask

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            op = 4'(k * 2);
            build(4'(k * 2), 1'b0, 1'b0, 0, 0);
            foreach (g_exp[i]) begin
                mem_rdy = g_rdy[i];
                @(negedge clk);
            end
        end
        #1;
        n_chk++;
        if (instr_cnt !== 16'd5) begin
            n_err++;
            $display("FAIL instr_cnt got %0d exp 5", instr_cnt);
        end
        force dut.r_instr_cnt = 16'hFFFF;
        #1 release dut.r_instr_cnt;
        op = 4'd9;
        build(4'd9, 1'b0, 1'b0, 0, 0);
        foreach (g_exp[i]) begin
            mem_rdy = g_rdy[i];
            @(negedge clk);
        end
        #1;
        n_chk++;
        if (instr_cnt !== 16'h0000) begin
            n_err++;
            $display("FAIL instr_cnt_wrap got %h exp 0000", instr_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_ldm_wait();
        test_cond_jumps();
        test_random_stream();
        test_reset_mid_stm();
        test_halt();
`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
